// File: rtl/jzjpcc_pkg.sv
// Shared types and constants for the jzjpcc pipeline.
package jzjpcc_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  localparam int unsigned REG_COUNT = 32;

endpackage

// File: rtl/jzjpcc_load_formatter.sv
// Extracts and sign/zero-extends the addressed byte or halfword of a loaded word.
module jzjpcc_load_formatter
  import jzjpcc_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_offset,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[8*byte_offset +: 8];
    // Halfword loads only look at the upper offset bit; misalignment is not this stage's concern.
    sel_half = byte_offset[1] ? word[31:16] : word[15:0];
    case (load_funct3_t'(funct3))
      LB:      result = {{24{sel_byte[7]}}, sel_byte};
      LBU:     result = {24'h000000, sel_byte};
      LH:      result = {{16{sel_half[15]}}, sel_half};
      LHU:     result = {16'h0000, sel_half};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/jzjpcc_writeback.sv
// Writeback stage: result select, integer register file with write-to-read bypass,
// forwarding bus to execute and retired-instruction counter.
module jzjpcc_writeback
  import jzjpcc_pkg::*;
#(
  parameter int unsigned INSTRET_WIDTH = 64,
  parameter bit          BYPASS_ENABLE = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [4:0]               rdAddr_writeback,
  input  logic                     rdWriteEnable_writeback,
  input  logic                     rdSource_writeback,
  input  logic [31:0]              memoryOut_writeback,
  input  logic [31:0]              aluResult_writeback,
  input  logic [2:0]               loadFunct3_writeback,
  input  logic [1:0]               loadByteOffset_writeback,
  input  logic                     instrRetired_writeback,
  input  logic [4:0]               rs1Addr_decode,
  input  logic [4:0]               rs2Addr_decode,
  output logic [31:0]              rs1Data_decode,
  output logic [31:0]              rs2Data_decode,
  output logic [31:0]              rdData_forward,
  output logic [4:0]               rdAddr_forward,
  output logic                     rdForwardValid,
  output logic [INSTRET_WIDTH-1:0] instret
);

  logic [31:0] regs [1:REG_COUNT-1];
  logic [31:0] load_data;

  jzjpcc_load_formatter u_load_formatter (
    .word        (memoryOut_writeback),
    .funct3      (loadFunct3_writeback),
    .byte_offset (loadByteOffset_writeback),
    .result      (load_data)
  );

  always_comb begin
    rdData_forward = rdSource_writeback ? load_data : aluResult_writeback;
    rdAddr_forward = rdAddr_writeback;
    rdForwardValid = rdWriteEnable_writeback && (rdAddr_writeback != 5'd0);
  end

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    if (reset || addr == 5'd0)
      return '0;
    else if (BYPASS_ENABLE && rdForwardValid && addr == rdAddr_writeback)
      return rdData_forward;
    else
      return regs[addr];
  endfunction

  always_comb begin
    rs1Data_decode = read_port(rs1Addr_decode);
    rs2Data_decode = read_port(rs2Addr_decode);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 1; i < REG_COUNT; i++)
        regs[i] <= '0;
    end else if (rdForwardValid) begin
      regs[rdAddr_writeback] <= rdData_forward;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      instret <= '0;
    else if (instrRetired_writeback)
      instret <= instret + INSTRET_WIDTH'(1);
  end

endmodule

// File: tb/tb_jzjpcc_writeback.sv
// Self-checking bench for jzjpcc_writeback: an 8-bit-counter bypassing build and a
// 64-bit-counter non-bypassing build share stimulus and a behavioural model.
module tb_jzjpcc_writeback;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rd = '0;
  logic        we = 1'b0;
  logic        src = 1'b0;
  logic [31:0] mem = '0;
  logic [31:0] alu = '0;
  logic [2:0]  f3 = '0;
  logic [1:0]  off = '0;
  logic        retired = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;

  logic [31:0] a_rs1, a_rs2, a_fwd, b_rs1, b_rs2, b_fwd;
  logic [4:0]  a_fwd_addr, b_fwd_addr;
  logic        a_valid, b_valid;
  logic [7:0]  a_instret;
  logic [63:0] b_instret;

  int unsigned checks = 0;
  int unsigned passes = 0;

  logic [31:0] m_regs [32];
  longint unsigned m_ret = 0;

  always #5 clock = ~clock;

  jzjpcc_writeback #(.INSTRET_WIDTH(8), .BYPASS_ENABLE(1'b1)) dut (
    .clock(clock), .reset(reset),
    .rdAddr_writeback(rd), .rdWriteEnable_writeback(we), .rdSource_writeback(src),
    .memoryOut_writeback(mem), .aluResult_writeback(alu),
    .loadFunct3_writeback(f3), .loadByteOffset_writeback(off),
    .instrRetired_writeback(retired),
    .rs1Addr_decode(rs1), .rs2Addr_decode(rs2),
    .rs1Data_decode(a_rs1), .rs2Data_decode(a_rs2),
    .rdData_forward(a_fwd), .rdAddr_forward(a_fwd_addr), .rdForwardValid(a_valid),
    .instret(a_instret)
  );

  jzjpcc_writeback #(.INSTRET_WIDTH(64), .BYPASS_ENABLE(1'b0)) dut_nb (
    .clock(clock), .reset(reset),
    .rdAddr_writeback(rd), .rdWriteEnable_writeback(we), .rdSource_writeback(src),
    .memoryOut_writeback(mem), .aluResult_writeback(alu),
    .loadFunct3_writeback(f3), .loadByteOffset_writeback(off),
    .instrRetired_writeback(retired),
    .rs1Addr_decode(rs1), .rs2Addr_decode(rs2),
    .rs1Data_decode(b_rs1), .rs2Data_decode(b_rs2),
    .rdData_forward(b_fwd), .rdAddr_forward(b_fwd_addr), .rdForwardValid(b_valid),
    .instret(b_instret)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] fn, input logic [1:0] o);
    logic [31:0] b, h;
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * o[1])) & 32'hFFFF;
    case (fn)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata();
    return src ? fmt(mem, f3, off) : alu;
  endfunction

  function automatic logic exp_valid();
    return we && rd != 5'd0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit bypass);
    if (reset || addr == 5'd0) return 32'h0;
    if (bypass && exp_valid() && addr == rd) return exp_wdata();
    return m_regs[addr];
  endfunction

  task automatic model_clear();
    foreach (m_regs[i]) m_regs[i] = '0;
    m_ret = 0;
  endtask

  task automatic step();
    @(posedge clock);
    if (!reset) begin
      if (exp_valid()) m_regs[rd] = exp_wdata();
      if (retired) m_ret++;
    end
    #1;
  endtask

  task automatic idle();
    we = 1'b0; retired = 1'b0; src = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    model_clear();
    rs1 = 5'd5; rs2 = 5'd31;
    #1;
    checks++; if (a_rs1 !== 32'h0) $display("FAIL reset_rs1 got %h want 0", a_rs1); else passes++;
    checks++; if (a_rs2 !== 32'h0) $display("FAIL reset_rs2 got %h want 0", a_rs2); else passes++;
    checks++; if (a_instret !== 8'h0) $display("FAIL reset_instret got %0d want 0", a_instret); else passes++;
    checks++; if (b_instret !== 64'h0) $display("FAIL reset_instret_nb got %0d want 0", b_instret); else passes++;
  endtask

  task automatic test_bypass();
    src = 1'b0; alu = 32'hDEADBEEF; rd = 5'd7; we = 1'b1; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    checks++; if (a_rs1 !== 32'hDEADBEEF) $display("FAIL bypass_rs1 got %h want deadbeef", a_rs1); else passes++;
    checks++; if (a_rs2 !== 32'hDEADBEEF) $display("FAIL bypass_rs2 got %h want deadbeef", a_rs2); else passes++;
    checks++; if (b_rs1 !== 32'h0) $display("FAIL nobypass_rs1 got %h want 0", b_rs1); else passes++;
    checks++; if (a_valid !== 1'b1) $display("FAIL bypass_valid got %b want 1", a_valid); else passes++;
    step();
    we = 1'b0; alu = 32'h0;
    #1;
    checks++; if (a_rs1 !== 32'hDEADBEEF) $display("FAIL stored_rs1 got %h want deadbeef", a_rs1); else passes++;
    checks++; if (b_rs1 !== 32'hDEADBEEF) $display("FAIL stored_rs1_nb got %h want deadbeef", b_rs1); else passes++;
  endtask

  task automatic test_x0();
    src = 1'b0; alu = 32'h12345678; rd = 5'd0; we = 1'b1; rs1 = 5'd0;
    #1;
    checks++; if (a_rs1 !== 32'h0) $display("FAIL x0_read got %h want 0", a_rs1); else passes++;
    checks++; if (a_valid !== 1'b0) $display("FAIL x0_valid got %b want 0", a_valid); else passes++;
    checks++; if (a_fwd !== 32'h12345678) $display("FAIL x0_fwd got %h want 12345678", a_fwd); else passes++;
    step();
    we = 1'b0;
    #1;
    checks++; if (a_rs1 !== 32'h0) $display("FAIL x0_after got %h want 0", a_rs1); else passes++;
  endtask

  task automatic test_load_format();
    logic [2:0]  t_f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
    logic [1:0]  t_off [6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0};
    logic [31:0] t_exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                               32'h00007F01, 32'h00007F01, 32'h80FF7F01};
    idle();
    src = 1'b1; mem = 32'h80FF7F01;
    for (int i = 0; i < 6; i++) begin
      f3 = t_f3[i]; off = t_off[i];
      #1;
      checks++;
      if (a_fwd !== t_exp[i]) $display("FAIL load_fmt[%0d] f3=%0d off=%0d got %h want %h", i, f3, off, a_fwd, t_exp[i]);
      else passes++;
    end
    src = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rd = 5'($urandom); we = ($urandom_range(0, 3) != 0); src = 1'($urandom);
      mem = $urandom; alu = $urandom; f3 = 3'($urandom); off = 2'($urandom);
      retired = 1'($urandom);
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      #1;
      checks++; if (a_fwd !== exp_wdata()) $display("FAIL rnd_fwd n=%0d got %h want %h", n, a_fwd, exp_wdata()); else passes++;
      checks++; if (a_valid !== exp_valid() || a_fwd_addr !== rd) $display("FAIL rnd_fwd_ctl n=%0d got %b/%0d want %b/%0d", n, a_valid, a_fwd_addr, exp_valid(), rd); else passes++;
      checks++; if (a_rs1 !== exp_read(rs1, 1)) $display("FAIL rnd_rs1 n=%0d got %h want %h", n, a_rs1, exp_read(rs1, 1)); else passes++;
      checks++; if (a_rs2 !== exp_read(rs2, 1)) $display("FAIL rnd_rs2 n=%0d got %h want %h", n, a_rs2, exp_read(rs2, 1)); else passes++;
      checks++; if (b_rs1 !== exp_read(rs1, 0)) $display("FAIL rnd_rs1_nb n=%0d got %h want %h", n, b_rs1, exp_read(rs1, 0)); else passes++;
      checks++; if (b_rs2 !== exp_read(rs2, 0)) $display("FAIL rnd_rs2_nb n=%0d got %h want %h", n, b_rs2, exp_read(rs2, 0)); else passes++;
      step();
      checks++; if (a_instret !== 8'(m_ret % 256)) $display("FAIL rnd_instret n=%0d got %0d want %0d", n, a_instret, m_ret % 256); else passes++;
      checks++; if (b_instret !== 64'(m_ret)) $display("FAIL rnd_instret_nb n=%0d got %0d want %0d", n, b_instret, m_ret); else passes++;
    end
    idle();
  endtask

  task automatic test_instret_wrap();
    int unsigned cycles = 0;
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_clear();
    while (m_ret < 255 && cycles < 2000) begin
      retired = ($urandom_range(0, 3) != 0);
      step();
      cycles++;
    end
    retired = 1'b0;
    checks++; if (a_instret !== 8'd255) $display("FAIL wrap_pre got %0d want 255", a_instret); else passes++;
    checks++; if (b_instret !== 64'd255) $display("FAIL wrap_pre_nb got %0d want 255", b_instret); else passes++;
    step();
    checks++; if (a_instret !== 8'd255) $display("FAIL wrap_bubble got %0d want 255", a_instret); else passes++;
    retired = 1'b1;
    step();
    retired = 1'b0;
    checks++; if (a_instret !== 8'd0) $display("FAIL wrap_post got %0d want 0", a_instret); else passes++;
    checks++; if (b_instret !== 64'd256) $display("FAIL wrap_post_nb got %0d want 256", b_instret); else passes++;
  endtask

  task automatic test_async_reset();
    retired = 1'b1;
    step();
    step();
    src = 1'b0; alu = 32'hCAFE0003; rd = 5'd3; we = 1'b1; rs1 = 5'd3; rs2 = 5'd3;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (a_instret !== 8'd0) $display("FAIL areset_instret got %0d want 0", a_instret); else passes++;
    checks++; if (b_instret !== 64'd0) $display("FAIL areset_instret_nb got %0d want 0", b_instret); else passes++;
    checks++; if (a_rs1 !== 32'h0) $display("FAIL areset_rs1 got %h want 0", a_rs1); else passes++;
    checks++; if (a_valid !== 1'b1 || a_fwd !== 32'hCAFE0003) $display("FAIL areset_fwd got %b/%h want 1/cafe0003", a_valid, a_fwd); else passes++;
    step();
    checks++; if (a_instret !== 8'd0) $display("FAIL areset_hold got %0d want 0", a_instret); else passes++;
    reset = 1'b0;
    model_clear();
    we = 1'b0; retired = 1'b0;
    #1;
    checks++; if (a_rs1 !== 32'h0) $display("FAIL areset_x3 got %h want 0", a_rs1); else passes++;
    checks++; if (b_rs2 !== 32'h0) $display("FAIL areset_x3_nb got %h want 0", b_rs2); else passes++;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_bypass();
    test_x0();
    test_load_format();
    test_random();
    test_instret_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
